multiple_list_sequencer: RTL and testbench

- Issue-side sequencer for Thumb PUSH, POP, LDM and STM.
- Accepts a decoded multiple-transfer instruction and walks its register list, one register per clock.
- Each cycle it drives the data-memory address, the register address, the remaining list, and the framing pulse/stable signals consumed by the downstream list delay stage.
- On completion it issues the base-register (Rn or SP) writeback and releases the pipeline stall.

---
 rtl/multiple_list_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_multiple_list_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multiple_list_sequencer.sv
// Issue-side sequencer for Thumb PUSH/POP/LDM/STM.
// Walks the latched register list one register per clock, driving the
// data-memory address, the register index and the remaining list, then
// issues the base-register writeback and releases the pipeline stall.
// All outputs are registered and depend only on internal state.
module multiple_list_sequencer #(
    parameter int ADDR_W = 32,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        multiple_vector,
    input  logic [8:0]        list_in,
    input  logic [2:0]        rn,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        reg_addr,
    output logic [9:0]        list,
    output logic              multiple_pulse,
    output logic              multiple_stable,
    output logic              stall,
    output logic              wb_en,
    output logic [3:0]        wb_reg,
    output logic [ADDR_W-1:0] wb_data,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);
    localparam logic [3:0]        SP_IDX = 4'd13;
    localparam logic [3:0]        LR_IDX = 4'd14;
    localparam logic [3:0]        PC_IDX = 4'd15;

    // Number of set bits in a 9-bit register list (0..9).
    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 9; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Index of the lowest set bit; 0 when the list is empty.
    function automatic logic [3:0] lowest_index(input logic [8:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 8; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Register number for the lowest pending bit; bit 8 is LR on PUSH, PC on POP.
    function automatic logic [3:0] issue_reg(input logic [8:0] v, input logic is_pop);
        logic [3:0] idx;
        idx = lowest_index(v);
        if (idx == 4'd8) begin
            idx = is_pop ? PC_IDX : LR_IDX;
        end
        return idx;
    endfunction

    state_t            state_q, state_d;
    logic              pop_q, pop_d;
    logic              wb_ok_q, wb_ok_d;
    logic [3:0]        wb_target_q, wb_target_d;
    logic [ADDR_W-1:0] final_base_q, final_base_d;

    logic [ADDR_W-1:0] dm_addr_d;
    logic [3:0]        reg_addr_d;
    logic [9:0]        list_d;
    logic              pulse_d, stable_d, stall_d, wb_en_d, done_d;
    logic [3:0]        wb_reg_d;
    logic [ADDR_W-1:0] wb_data_d;

    // Decode helpers for the incoming instruction.
    logic [8:0]        masked_in;
    logic [3:0]        cnt_in;
    logic [ADDR_W-1:0] span_in;
    logic              is_push_in;
    logic [8:0]        rest;

    always_comb begin
        masked_in  = list_in & {multiple_vector[1], 8'hFF};
        cnt_in     = popcount9(masked_in);
        span_in    = STEP_W * ADDR_W'(cnt_in);
        is_push_in = (multiple_vector == 2'b10);
        rest       = list[8:0] & (list[8:0] - 9'd1);
    end

    // Next-state and next-output decode for the sequencer FSM.
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        pop_d        = pop_q;
        wb_ok_d      = wb_ok_q;
        wb_target_d  = wb_target_q;
        final_base_d = final_base_q;
        dm_addr_d    = dm_addr;
        reg_addr_d   = reg_addr;
        list_d       = list;
        pulse_d      = 1'b0;
        stable_d     = 1'b0;
        stall_d      = 1'b0;
        wb_en_d      = 1'b0;
        wb_reg_d     = '0;
        wb_data_d    = '0;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                dm_addr_d  = '0;
                reg_addr_d = '0;
                list_d     = '0;
                if (start) begin
                    pop_d        = (multiple_vector == 2'b11);
                    wb_target_d  = multiple_vector[1] ? SP_IDX : {1'b0, rn};
                    // A loaded base register overrides the writeback on LDM.
                    wb_ok_d      = (cnt_in != 4'd0) &&
                                   !((multiple_vector == 2'b01) && masked_in[rn]);
                    final_base_d = is_push_in ? (base_addr - span_in) : (base_addr + span_in);
                    if (cnt_in != 4'd0) begin
                        state_d    = XFER;
                        dm_addr_d  = is_push_in ? (base_addr - span_in) : base_addr;
                        reg_addr_d = issue_reg(masked_in, multiple_vector == 2'b11);
                        list_d     = {1'b0, masked_in};
                        pulse_d    = 1'b1;
                        stable_d   = 1'b1;
                        stall_d    = 1'b1;
                    end else begin
                        state_d = WB;
                    end
                end
            end

            XFER: begin
                if (rest == '0) begin
                    state_d = WB;
                end else begin
                    list_d     = {1'b0, rest};
                    dm_addr_d  = dm_addr + STEP_W;
                    reg_addr_d = issue_reg(rest, pop_q);
                    stable_d   = 1'b1;
                    stall_d    = 1'b1;
                end
            end

            WB: begin
                state_d    = IDLE;
                dm_addr_d  = '0;
                reg_addr_d = '0;
                list_d     = '0;
            end

            default: begin
                state_d    = IDLE;
                dm_addr_d  = '0;
                reg_addr_d = '0;
                list_d     = '0;
            end
        endcase

        // Entering WB: the list is exhausted; address and register hold.
        if (state_d == WB) begin
            list_d    = '0;
            done_d    = 1'b1;
            stall_d   = 1'b1;
            wb_en_d   = wb_ok_d;
            wb_reg_d  = wb_target_d;
            wb_data_d = final_base_d;
        end
    end

    // State, latched instruction context and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            pop_q           <= 1'b0;
            wb_ok_q         <= 1'b0;
            wb_target_q     <= '0;
            final_base_q    <= '0;
            dm_addr         <= '0;
            reg_addr        <= '0;
            list            <= '0;
            multiple_pulse  <= 1'b0;
            multiple_stable <= 1'b0;
            stall           <= 1'b0;
            wb_en           <= 1'b0;
            wb_reg          <= '0;
            wb_data         <= '0;
            done            <= 1'b0;
        end else begin
            state_q         <= state_d;
            pop_q           <= pop_d;
            wb_ok_q         <= wb_ok_d;
            wb_target_q     <= wb_target_d;
            final_base_q    <= final_base_d;
            dm_addr         <= dm_addr_d;
            reg_addr        <= reg_addr_d;
            list            <= list_d;
            multiple_pulse  <= pulse_d;
            multiple_stable <= stable_d;
            stall           <= stall_d;
            wb_en           <= wb_en_d;
            wb_reg          <= wb_reg_d;
            wb_data         <= wb_data_d;
            done            <= done_d;
        end
    end

endmodule

// File: tb/tb_multiple_list_sequencer.sv
// Directed bench for multiple_list_sequencer: PUSH, POP, LDM, STM with wrap,
// empty list, and a mid-sequence reset abort followed by a fresh instruction.
module tb_multiple_list_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  multiple_vector;
    logic [8:0]  list_in;
    logic [2:0]  rn;
    logic [31:0] base_addr;
    logic [31:0] dm_addr;
    logic [3:0]  reg_addr;
    logic [9:0]  list;
    logic        multiple_pulse;
    logic        multiple_stable;
    logic        stall;
    logic        wb_en;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    multiple_list_sequencer #(.ADDR_W(32), .STEP(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .multiple_vector (multiple_vector),
        .list_in         (list_in),
        .rn              (rn),
        .base_addr       (base_addr),
        .dm_addr         (dm_addr),
        .reg_addr        (reg_addr),
        .list            (list),
        .multiple_pulse  (multiple_pulse),
        .multiple_stable (multiple_stable),
        .stall           (stall),
        .wb_en           (wb_en),
        .wb_reg          (wb_reg),
        .wb_data         (wb_data),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag,
                              input logic [31:0] e_dm, input logic [3:0] e_reg,
                              input logic [9:0] e_list, input logic e_pulse,
                              input logic e_stable, input logic e_stall,
                              input logic e_wb_en, input logic [3:0] e_wb_reg,
                              input logic [31:0] e_wb_data, input logic e_done);
        check({tag, ".dm_addr"},  dm_addr,                  e_dm);
        check({tag, ".reg_addr"}, {28'd0, reg_addr},        {28'd0, e_reg});
        check({tag, ".list"},     {22'd0, list},            {22'd0, e_list});
        check({tag, ".pulse"},    {31'd0, multiple_pulse},  {31'd0, e_pulse});
        check({tag, ".stable"},   {31'd0, multiple_stable}, {31'd0, e_stable});
        check({tag, ".stall"},    {31'd0, stall},           {31'd0, e_stall});
        check({tag, ".wb_en"},    {31'd0, wb_en},           {31'd0, e_wb_en});
        check({tag, ".wb_reg"},   {28'd0, wb_reg},          {28'd0, e_wb_reg});
        check({tag, ".wb_data"},  wb_data,                  e_wb_data);
        check({tag, ".done"},     {31'd0, done},            {31'd0, e_done});
    endtask

    task automatic expect_idle(input string tag);
        expect_out(tag, 32'h0, 4'd0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    endtask

    task automatic issue(input logic [1:0] mv, input logic [8:0] l,
                         input logic [2:0] r, input logic [31:0] b);
        multiple_vector = mv;
        list_in         = l;
        rn              = r;
        base_addr       = b;
        start           = 1'b1;
        tick();
        start           = 1'b0;
        // Scramble inputs so only latched values can produce correct outputs.
        multiple_vector = ~mv;
        list_in         = 9'h1FF;
        rn              = ~r;
        base_addr       = 32'hDEAD_BEEF;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; multiple_vector = '0; list_in = '0; rn = '0; base_addr = '0;
        tick();
        tick();
        expect_idle("reset");
        rst = 1'b1;
        tick();
        expect_idle("idle");

        // PUSH {R0,R2,LR}
        issue(2'b10, 9'h105, 3'd0, 32'h2000_0100);
        expect_out("push.x0", 32'h2000_00F4, 4'd0,  10'h105, 1, 1, 1, 0, 4'd0, 32'h0, 0);
        tick();
        expect_out("push.x1", 32'h2000_00F8, 4'd2,  10'h104, 0, 1, 1, 0, 4'd0, 32'h0, 0);
        tick();
        expect_out("push.x2", 32'h2000_00FC, 4'd14, 10'h100, 0, 1, 1, 0, 4'd0, 32'h0, 0);
        tick();
        expect_out("push.wb", 32'h2000_00FC, 4'd14, 10'h000, 0, 0, 1, 1, 4'd13, 32'h2000_00F4, 1);
        tick();
        expect_idle("push.idle");

        // POP {R1,PC}
        issue(2'b11, 9'h102, 3'd0, 32'h2000_00F0);
        expect_out("pop.x0", 32'h2000_00F0, 4'd1,  10'h102, 1, 1, 1, 0, 4'd0, 32'h0, 0);
        tick();
        expect_out("pop.x1", 32'h2000_00F4, 4'd15, 10'h100, 0, 1, 1, 0, 4'd0, 32'h0, 0);
        tick();
        expect_out("pop.wb", 32'h2000_00F4, 4'd15, 10'h000, 0, 0, 1, 1, 4'd13, 32'h2000_00F8, 1);
        tick();
        expect_idle("pop.idle");

        // LDM R3!, {R0,R3}: base register loaded, no writeback
        issue(2'b01, 9'h009, 3'd3, 32'h0000_0100);
        expect_out("ldm.x0", 32'h100, 4'd0, 10'h009, 1, 1, 1, 0, 4'd0, 32'h0, 0);
        tick();
        expect_out("ldm.x1", 32'h104, 4'd3, 10'h008, 0, 1, 1, 0, 4'd0, 32'h0, 0);
        tick();
        expect_out("ldm.wb", 32'h104, 4'd3, 10'h000, 0, 0, 1, 0, 4'd3, 32'h108, 1);
        tick();
        expect_idle("ldm.idle");

        // STM R1!, {R1..R7} across the top of the address space
        issue(2'b00, 9'h0FE, 3'd1, 32'hFFFF_FFF8);
        expect_out("stm.x0", 32'hFFFF_FFF8, 4'd1, 10'h0FE, 1, 1, 1, 0, 4'd0, 32'h0, 0);
        for (int i = 1; i < 7; i++) begin
            logic [9:0] rem;
            rem = (10'h0FE >> (i + 1)) << (i + 1);
            tick();
            expect_out($sformatf("stm.x%0d", i), 32'hFFFF_FFF8 + 32'(4 * i), 4'(i + 1),
                       rem, 0, 1, 1, 0, 4'd0, 32'h0, 0);
        end
        tick();
        expect_out("stm.wb", 32'h0000_0010, 4'd7, 10'h000, 0, 0, 1, 1, 4'd1, 32'h0000_0014, 1);
        tick();
        expect_idle("stm.idle");

        // STM with only bit 8 set: bit 8 is ignored, so the list is empty
        issue(2'b00, 9'h100, 3'd0, 32'h0000_0300);
        expect_out("empty.wb", 32'h0, 4'd0, 10'h000, 0, 0, 1, 0, 4'd0, 32'h300, 1);
        tick();
        expect_idle("empty.idle");

        // 5-register LDM aborted by reset in its second transfer cycle
        issue(2'b01, 9'h01F, 3'd7, 32'h0000_0200);
        expect_out("abort.x0", 32'h200, 4'd0, 10'h01F, 1, 1, 1, 0, 4'd0, 32'h0, 0);
        multiple_vector = 2'b10; list_in = 9'h1FF; rn = 3'd0; base_addr = 32'h5000;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("abort.x1", 32'h204, 4'd1, 10'h01E, 0, 1, 1, 0, 4'd0, 32'h0, 0);
        rst = 1'b0;
        start = 1'b1;
        tick();
        expect_idle("abort.rst");
        rst = 1'b1;
        start = 1'b0;
        tick();
        expect_idle("abort.idle0");
        tick();
        expect_idle("abort.idle1");

        // Fresh STM R2!, {R0,R1} after the abort
        issue(2'b00, 9'h003, 3'd2, 32'h0000_0040);
        expect_out("fresh.x0", 32'h40, 4'd0, 10'h003, 1, 1, 1, 0, 4'd0, 32'h0, 0);
        tick();
        expect_out("fresh.x1", 32'h44, 4'd1, 10'h002, 0, 1, 1, 0, 4'd0, 32'h0, 0);
        tick();
        expect_out("fresh.wb", 32'h44, 4'd1, 10'h000, 0, 0, 1, 1, 4'd2, 32'h48, 1);
        tick();
        expect_idle("fresh.idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
